// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared constants and types for the millisecond up/down timer.
//   TIMER_WIDTH  : width of the millisecond value (max 2047 ms at 11 bits)
//   CLK_FREQ_HZ  : system clock frequency
//   CLKS_PER_MS  : clock cycles per millisecond tick, derived from CLK_FREQ_HZ
//   dir_e        : counting direction
//   prescaler_width() : bit width needed to count 0..n-1 (minimum 1 bit)
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 11;
  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned CLKS_PER_MS = CLK_FREQ_HZ / 1000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // A one-cycle period still needs a 1-bit register to keep widths legal.
  function automatic int unsigned prescaler_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// ---------------------------------------------------------------------------
// ms_prescaler
//   Divides the system clock down to one tick per millisecond. The phase
//   counter only advances while enable is high, so pausing keeps the partial
//   millisecond.
//   Ports:
//     clk    : system clock, rising-edge active
//     reset  : asynchronous active-low reset, clears the phase to 0
//     enable : 1 = advance phase, 0 = hold
//     tick   : one-cycle pulse on the edge where the phase wraps
// ---------------------------------------------------------------------------
module ms_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = timer_pkg::CLKS_PER_MS
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned     PW   = prescaler_width(CLKS_PER_MS);
  localparam logic [PW-1:0]   LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] phase;
  logic          at_last;

  assign at_last = (phase == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (enable) begin
      phase <= at_last ? '0 : phase + PW'(1);
    end
  end

  // Tick is combinational so the counter updates on the same edge the
  // phase wraps.
  assign tick = enable & at_last;

endmodule

// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer
//   Millisecond up/down timer with saturating count.
//   Ports:
//     clk         : system clock, rising-edge active
//     reset       : asynchronous active-low reset/load
//     up          : 1 = count up from 0, 0 = count down from start_value
//     start_value : countdown start value, used only while reset is low
//     enable      : 1 = run, 0 = pause (prescaler and value frozen)
//     timer_value : current time in ms
// ---------------------------------------------------------------------------
module timer
  import timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = timer_pkg::CLKS_PER_MS,
  parameter int unsigned WIDTH       = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic [WIDTH-1:0] start_value,
  input  logic             enable,
  output logic [WIDTH-1:0] timer_value
);

  logic             tick;
  dir_e             dir;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  ms_prescaler #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign dir = up ? DIR_UP : DIR_DOWN;

  always_comb begin
    load_value = '0;
    if (dir == DIR_DOWN) begin
      load_value = start_value;
    end
  end

  // Saturating step: holds at all-ones going up and at zero going down.
  always_comb begin
    count_next = count;
    if (tick) begin
      case (dir)
        DIR_UP:   if (count != '1) count_next = count + WIDTH'(1);
        DIR_DOWN: if (count != '0) count_next = count - WIDTH'(1);
        default:  count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= load_value;
    end else begin
      count <= count_next;
    end
  end

  // The register captures the load value at reset assertion and on every
  // edge during reset; the bypass makes the output follow up/start_value
  // continuously while reset is held, even between edges.
  assign timer_value = reset ? count : load_value;

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer
//   Self-checking bench for timer, run with a short millisecond period so
//   saturation is reachable in a few thousand cycles.
// ---------------------------------------------------------------------------
module tb_timer;
  import timer_pkg::*;

  localparam int unsigned CPM  = 5;
  localparam int unsigned W    = TIMER_WIDTH;
  localparam int unsigned MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         up;
  logic         enable;
  logic [W-1:0] start_value;
  logic [W-1:0] timer_value;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: value in ms and total enabled cycles since reset.
  int unsigned m_val = 0;
  int unsigned m_en  = 0;

  timer #(
    .CLKS_PER_MS (CPM),
    .WIDTH       (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .up          (up),
    .start_value (start_value),
    .enable      (enable),
    .timer_value (timer_value)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned load_val();
    return up ? 0 : int'(start_value);
  endfunction

  function automatic int unsigned expected();
    return reset ? m_val : load_val();
  endfunction

  task automatic check(input string name, input int unsigned exp);
    n_tests++;
    if (timer_value !== W'(exp)) begin
      n_fail++;
      $display("FAIL %s: timer_value=%0d expected=%0d at %0t", name, timer_value, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic u, input logic e, input int unsigned sv);
    up          = u;
    enable      = e;
    start_value = W'(sv);
    if (reset && !r) begin
      m_val = load_val();
      m_en  = 0;
    end
    reset = r;
  endtask

  // Model behaviour at a rising edge: every CPM-th enabled cycle is a tick.
  task automatic model_edge();
    if (!reset) begin
      m_val = load_val();
      m_en  = 0;
    end else if (enable) begin
      m_en++;
      if (m_en % CPM == 0) begin
        if (up) m_val = (m_val >= MAXV) ? MAXV : m_val + 1;
        else    m_val = (m_val == 0) ? 0 : m_val - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) cycle();
  endtask

  typedef struct {
    logic        r;
    logic        u;
    logic        e;
    int unsigned sv;
    int unsigned n;
    int unsigned exp;
    string       name;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic r_nxt;
    logic u_nxt;

    tbl[0]  = '{1'b0, 1'b1, 1'b1,   0,  2,  0, "reset_up"};
    tbl[1]  = '{1'b1, 1'b1, 1'b1,   0,  1,  0, "release_plus1"};
    tbl[2]  = '{1'b1, 1'b1, 1'b1,   0,  4,  1, "first_tick"};
    tbl[3]  = '{1'b1, 1'b1, 1'b1,   0, 10,  3, "up_3ms"};
    tbl[4]  = '{1'b1, 1'b1, 1'b0,   0,  7,  3, "pause_hold"};
    tbl[5]  = '{1'b1, 1'b1, 1'b1,   0,  4,  3, "resume_phase"};
    tbl[6]  = '{1'b1, 1'b1, 1'b1,   0,  1,  4, "resume_tick"};
    tbl[7]  = '{1'b1, 1'b0, 1'b1,   0,  5,  3, "dir_change"};
    tbl[8]  = '{1'b0, 1'b0, 1'b1,   7,  1,  7, "load_7"};
    tbl[9]  = '{1'b1, 1'b0, 1'b1,   7,  5,  6, "down_6"};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 100,  5,  5, "sv_ignored"};
    tbl[11] = '{1'b0, 1'b0, 1'b1,   1,  1,  1, "load_1"};
    tbl[12] = '{1'b1, 1'b0, 1'b1,   1, 15,  0, "down_sat0"};
    tbl[13] = '{1'b0, 1'b0, 1'b0,   0,  1,  0, "load_0"};
    tbl[14] = '{1'b1, 1'b0, 1'b1,   0, 10,  0, "zero_start"};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 500,  1,  0, "up_ignores_sv"};

    reset       = 1'b0;
    up          = 1'b1;
    enable      = 1'b1;
    start_value = '0;
    cycle();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].u, tbl[i].e, tbl[i].sv);
      run(tbl[i].n);
      check(tbl[i].name, tbl[i].exp);
    end

    // Asynchronous load between edges, continuous while reset is held.
    drive(1'b1, 1'b0, 1'b1, 0);
    run(3);
    drive(1'b0, 1'b0, 1'b1, 9);
    #1 check("async_load", 9);
    drive(1'b0, 1'b1, 1'b1, 9);
    #1 check("async_up_zero", 0);
    run(2);

    // Reset mid-period, released between edges.
    drive(1'b1, 1'b1, 1'b1, 0);
    run(15);
    check("up_to_3", 3);
    run(2);
    #4 drive(1'b0, 1'b1, 1'b1, 0);
    #1 check("midcount_reset", 0);
    #3 drive(1'b1, 1'b1, 1'b1, 0);
    run(CPM - 1);
    check("post_reset_before_tick", 0);
    run(1);
    check("post_reset_tick", 1);

    // Pause keeps the partial millisecond.
    drive(1'b0, 1'b0, 1'b1, 7);
    run(1);
    drive(1'b1, 1'b0, 1'b1, 7);
    run(2 * CPM);
    check("down_to_5", 5);
    run(3);
    drive(1'b1, 1'b0, 1'b0, 7);
    run(10);
    check("pause_5", 5);
    drive(1'b1, 1'b0, 1'b1, 7);
    run(CPM - 4);
    check("resume_before_tick", 5);
    run(1);
    check("preserved_phase", 4);

    // Count-up saturation, then reverse from the top.
    drive(1'b0, 1'b1, 1'b1, 0);
    run(1);
    drive(1'b1, 1'b1, 1'b1, 0);
    run((MAXV - 1) * CPM);
    check("near_max", MAXV - 1);
    run(CPM);
    check("reach_max", MAXV);
    run(3 * CPM);
    check("sat_hold", MAXV);
    drive(1'b1, 1'b0, 1'b1, 0);
    run(CPM);
    check("down_from_max", MAXV - 1);

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r_nxt = reset;
      if (!reset) r_nxt = ($urandom_range(1, 0) == 1);
      else if ($urandom_range(99, 0) == 0) r_nxt = 1'b0;
      u_nxt = up;
      if ($urandom_range(49, 0) == 0) u_nxt = ~up;
      drive(r_nxt, u_nxt, ($urandom_range(3, 0) != 0), $urandom_range(MAXV, 0));
      if (!r_nxt) begin
        #1 check("random_async", expected());
      end
      cycle();
      check("random", expected());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Millisecond up/down timer, clocked from the 50 MHz system clock (20 ns period).
- An internal prescaler produces one tick per millisecond. Each tick increments or decrements an 11-bit millisecond value.
- Reset loads the count: 0 when counting up, start_value when counting down.
- Enable pauses and resumes counting without losing state. Used as a stopwatch or countdown source in game/reaction logic.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick (50 MHz clock).
- WIDTH, 11, width of start_value and timer_value (max 2047 ms).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset/load.
- up  input  1  direction: 1 = count up from 0, 0 = count down from start_value.
- start_value  input  WIDTH  countdown start value in ms; sampled while reset is asserted.
- enable  input  1  1 = run, 0 = pause (hold all state).
- timer_value  output  WIDTH  current time in ms, registered.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-low.
- While reset = 0, asynchronously and continuously:
  - prescaler is cleared to 0;
  - timer_value = up ? 0 : start_value.
  - This holds regardless of enable.
- Reset release: counting starts on the first rising edge after reset returns high.
- Prescaler: counts 0..CLKS_PER_MS-1 on each edge where enable = 1.
  - When the prescaler equals CLKS_PER_MS-1 with enable = 1, it wraps to 0 and raises a one-cycle internal tick.
  - The first tick therefore occurs exactly CLKS_PER_MS enabled cycles after reset release.
- On tick:
  - up = 1: timer_value increments, saturating at 2^WIDTH-1 (no wrap).
  - up = 0: timer_value decrements, saturating at 0 (no wrap).
  - Direction is sampled at the tick. Changing up without reset only changes direction from the next tick; it does not reload.
- Pause: enable = 0 freezes both prescaler and timer_value. Re-asserting enable resumes from the frozen prescaler phase, so partial-millisecond progress is kept.
- Input sampling: start_value is ignored when reset is high. enable = 0 has no effect on reset loading.
- Latency: timer_value updates on the same edge as the tick; no extra output pipeline.
- Arithmetic: prescaler width is ceil(log2(CLKS_PER_MS)) bits, 16 for the default. All arithmetic is unsigned.
- Boundaries:
  - Countdown from start_value = 0 stays at 0.
  - Count up stops at 2047.

Decomposition:
- Shared package timer_pkg holds:
  - TIMER_WIDTH = 11;
  - CLK_FREQ_HZ = 50_000_000;
  - CLKS_PER_MS derived from CLK_FREQ_HZ.
- One natural sub-module: ms_prescaler.
  - Inputs: clk, reset, enable.
  - Output: one-cycle tick.
  - Parameter: CLKS_PER_MS.
- timer instantiates ms_prescaler and contains the up/down saturating counter.

Test Plan:
- Count up: up = 1, enable = 1. Pulse reset low for 1 cycle, then release. timer_value is 0 immediately and 0 one cycle after release, then 1/2/3 at 1/2/3 ms after release; exactly 3 at release + 3 ms + 20 ns.
- Countdown: start_value = 7, up = 0. Assert reset. timer_value is 7 during reset (asynchronous). After release it reads 7, then 6 at +1 ms and 5 at +2 ms.
- Pause: at value 5, drop enable for 2 ms. timer_value stays 5 and the prescaler does not advance. Re-enable for 1.5 ms: value is 4, with the tick arriving at the preserved phase.
- Saturation: up = 0, start_value = 1. Run 3 ms: value reads 1→0 and then stays 0. With up = 1 and CLKS_PER_MS reduced to 4, run past 2047 ticks: value holds at 2047.
- Reset mid-count: while counting up at value 3 with the prescaler mid-period, assert reset asynchronously between edges. timer_value goes to 0 immediately. After release, the next increment arrives exactly CLKS_PER_MS cycles later.
- Direction change without reset: count up to 4 ms, then set up = 0. The value continues from 4 and decrements to 3 at the next tick; no reload to start_value.
